// File: rtl/phase_step_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// phase_step_sweep_ctrl
//
// Purpose:
//   Generates the phase-accumulator step for the DDS waveform generator.
//   Three operating modes are selected at load time:
//     - fixed power-of-two frequency (step = BASE_STEP << sel)
//     - one-shot linear up-sweep (chirp) from start to stop
//     - continuous triangle sweep between start and stop
//   Sweep steps advance only on the sample-rate strobe, so the downstream
//   phase accumulator and filter test path see a step that changes once per
//   dwell period, aligned to a sample boundary.
//
// Ports:
//   i_clk         system clock, rising edge
//   i_rst_n       asynchronous active-low reset
//   i_load        one-cycle pulse: latch configuration, (re)start mode
//   i_mode        00 fixed, 01 up-sweep, 10 triangle, 11 treated as fixed
//   i_sel         fixed-mode select
//   i_start_step  sweep start step
//   i_stop_step   sweep stop step
//   i_inc         step increment per dwell period
//   i_dwell       sample enables per sweep step (0 behaves as 1)
//   i_sample_en   sample-rate strobe
//   i_hold        freezes dwell counter and step while high
//   o_phase_step  registered phase step
//   o_step_valid  high once any configuration has been loaded
//   o_busy        high while sweeping up or down
//   o_sweep_done  one-cycle completion pulse
// ---------------------------------------------------------------------------
module phase_step_sweep_ctrl #(
  parameter int                 PHASE_W   = 32,
  parameter int                 SEL_W     = 2,
  parameter int                 DWELL_W   = 16,
  parameter logic [PHASE_W-1:0] BASE_STEP = 'h0080_0000
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_load,
  input  logic [1:0]         i_mode,
  input  logic [SEL_W-1:0]   i_sel,
  input  logic [PHASE_W-1:0] i_start_step,
  input  logic [PHASE_W-1:0] i_stop_step,
  input  logic [PHASE_W-1:0] i_inc,
  input  logic [DWELL_W-1:0] i_dwell,
  input  logic               i_sample_en,
  input  logic               i_hold,
  output logic [PHASE_W-1:0] o_phase_step,
  output logic               o_step_valid,
  output logic               o_busy,
  output logic               o_sweep_done
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FIXED,
    ST_SWEEP_UP,
    ST_SWEEP_DOWN,
    ST_DONE
  } state_t;

  localparam logic [1:0] MODE_UP  = 2'b01;
  localparam logic [1:0] MODE_TRI = 2'b10;

  // -------------------------------------------------------------------------
  // State and latched configuration
  // -------------------------------------------------------------------------
  state_t             state_reg;
  logic [PHASE_W-1:0] step_reg;
  logic               valid_reg;
  logic               busy_reg;
  logic               done_reg;
  logic [DWELL_W-1:0] dwell_cnt_reg;

  logic [1:0]         mode_reg;
  logic [SEL_W-1:0]   sel_reg;
  logic [PHASE_W-1:0] start_reg;
  logic [PHASE_W-1:0] stop_reg;
  logic [PHASE_W-1:0] inc_reg;
  logic [DWELL_W-1:0] dwell_reg;

  // -------------------------------------------------------------------------
  // Load-time decode (uses the live inputs, since the load itself is what
  // latches them)
  // -------------------------------------------------------------------------
  logic               load_is_fixed;
  logic               load_cfg_ok;
  logic [PHASE_W-1:0] fixed_step_in;

  assign load_is_fixed = (i_mode != MODE_UP) && (i_mode != MODE_TRI);
  assign load_cfg_ok   = (i_start_step <= i_stop_step) && (i_inc != '0);
  assign fixed_step_in = BASE_STEP << i_sel;

  // Fixed step recomputed from the latched select; identical to the value
  // loaded, it just keeps the step a pure function of the latched config.
  logic [PHASE_W-1:0] fixed_step_lat;
  assign fixed_step_lat = BASE_STEP << sel_reg;

  // -------------------------------------------------------------------------
  // Dwell timing
  // -------------------------------------------------------------------------
  logic [DWELL_W-1:0] dwell_last;
  logic               dwell_tick;
  logic               dwell_wrap;

  // A dwell of 0 behaves exactly like a dwell of 1 (advance every enable).
  assign dwell_last = (dwell_reg == '0) ? '0 : (dwell_reg - DWELL_W'(1));
  assign dwell_tick = i_sample_en && !i_hold;
  assign dwell_wrap = dwell_tick && (dwell_cnt_reg == dwell_last);

  // -------------------------------------------------------------------------
  // Step arithmetic, one extra bit so carry and borrow are visible
  // -------------------------------------------------------------------------
  logic [PHASE_W:0]   up_sum;
  logic               up_hit_stop;
  logic [PHASE_W:0]   dn_diff;
  logic               dn_hit_start;

  assign up_sum      = {1'b0, step_reg} + {1'b0, inc_reg};
  assign up_hit_stop = (up_sum >= {1'b0, stop_reg});

  // Bit PHASE_W set means the subtraction borrowed past zero.
  assign dn_diff      = {1'b0, step_reg} - {1'b0, inc_reg};
  assign dn_hit_start = dn_diff[PHASE_W] || (dn_diff[PHASE_W-1:0] <= start_reg);

  // -------------------------------------------------------------------------
  // Main state machine: every output is registered alongside the state.
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg     <= ST_IDLE;
      step_reg      <= '0;
      valid_reg     <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      dwell_cnt_reg <= '0;
      mode_reg      <= '0;
      sel_reg       <= '0;
      start_reg     <= '0;
      stop_reg      <= '0;
      inc_reg       <= '0;
      dwell_reg     <= '0;
    end else begin
      // Completion is a pulse; only the transitions below re-assert it.
      done_reg <= 1'b0;

      if (i_load) begin
        // A load wins over anything else this cycle, including a pending
        // advance; a sweep in progress is abandoned without a done pulse.
        mode_reg      <= i_mode;
        sel_reg       <= i_sel;
        start_reg     <= i_start_step;
        stop_reg      <= i_stop_step;
        inc_reg       <= i_inc;
        dwell_reg     <= i_dwell;
        dwell_cnt_reg <= '0;
        valid_reg     <= 1'b1;

        if (load_is_fixed) begin
          state_reg <= ST_FIXED;
          step_reg  <= fixed_step_in;
          busy_reg  <= 1'b0;
        end else if (load_cfg_ok) begin
          state_reg <= ST_SWEEP_UP;
          step_reg  <= i_start_step;
          busy_reg  <= 1'b1;
        end else begin
          // Unusable sweep: park on start and report completion at once.
          state_reg <= ST_DONE;
          step_reg  <= i_start_step;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b1;
        end
      end else begin
        case (state_reg)
          ST_SWEEP_UP: begin
            if (dwell_tick) begin
              if (dwell_wrap) begin
                dwell_cnt_reg <= '0;
                if (up_hit_stop) begin
                  // Clamp to stop; never wrap through the top of the range.
                  step_reg <= stop_reg;
                  if (mode_reg == MODE_TRI) begin
                    state_reg <= ST_SWEEP_DOWN;
                  end else begin
                    state_reg <= ST_DONE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b1;
                  end
                end else begin
                  step_reg <= up_sum[PHASE_W-1:0];
                end
              end else begin
                dwell_cnt_reg <= dwell_cnt_reg + DWELL_W'(1);
              end
            end
          end

          ST_SWEEP_DOWN: begin
            if (dwell_tick) begin
              if (dwell_wrap) begin
                dwell_cnt_reg <= '0;
                if (dn_hit_start) begin
                  // Back at start: one triangle period complete.
                  step_reg  <= start_reg;
                  state_reg <= ST_SWEEP_UP;
                  done_reg  <= 1'b1;
                end else begin
                  step_reg <= dn_diff[PHASE_W-1:0];
                end
              end else begin
                dwell_cnt_reg <= dwell_cnt_reg + DWELL_W'(1);
              end
            end
          end

          ST_FIXED: begin
            step_reg <= fixed_step_lat;
          end

          default: begin
            // IDLE and DONE hold their step; strobes and hold are ignored.
          end
        endcase
      end
    end
  end

  assign o_phase_step = step_reg;
  assign o_step_valid = valid_reg;
  assign o_busy       = busy_reg;
  assign o_sweep_done = done_reg;

endmodule

// File: tb/tb_phase_step_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// tb_phase_step_sweep_ctrl
//
// Self-checking bench. The reference model expands each loaded sweep into
// its full list of step values up front (plain arithmetic) and then walks
// an index through that list once per dwell period.
// ---------------------------------------------------------------------------
module tb_phase_step_sweep_ctrl;

  localparam int          PW   = 32;
  localparam int          SW   = 2;
  localparam int          DW   = 16;
  localparam logic [31:0] BASE = 32'h0080_0000;

  localparam int K_IDLE  = 0;
  localparam int K_HOLD  = 1;
  localparam int K_SWEEP = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load = 1'b0;
  logic [1:0]    mode = '0;
  logic [SW-1:0] sel = '0;
  logic [PW-1:0] start_step = '0;
  logic [PW-1:0] stop_step = '0;
  logic [PW-1:0] inc = '0;
  logic [DW-1:0] dwell = '0;
  logic          sample_en = 1'b0;
  logic          hold = 1'b0;
  logic [PW-1:0] phase_step;
  logic          step_valid;
  logic          busy;
  logic          sweep_done;

  int vectors = 0;
  int miscompares = 0;

  phase_step_sweep_ctrl dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_load       (load),
    .i_mode       (mode),
    .i_sel        (sel),
    .i_start_step (start_step),
    .i_stop_step  (stop_step),
    .i_inc        (inc),
    .i_dwell      (dwell),
    .i_sample_en  (sample_en),
    .i_hold       (hold),
    .o_phase_step (phase_step),
    .o_step_valid (step_valid),
    .o_busy       (busy),
    .o_sweep_done (sweep_done)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int          m_kind;
  logic [31:0] m_seq[$];
  int          m_idx;
  int          m_cnt;
  int          m_dwell;
  bit          m_tri;
  logic        m_valid;
  logic        m_done;

  function automatic void model_reset();
    m_kind  = K_IDLE;
    m_seq.delete();
    m_idx   = 0;
    m_cnt   = 0;
    m_dwell = 1;
    m_tri   = 0;
    m_valid = 1'b0;
    m_done  = 1'b0;
  endfunction

  function automatic void model_load();
    longint s;
    logic [31:0] f;
    m_seq.delete();
    m_valid = 1'b1;
    m_idx   = 0;
    m_cnt   = 0;
    m_dwell = (dwell == 0) ? 1 : int'(dwell);
    m_tri   = (mode == 2'b10);
    if (mode == 2'b00 || mode == 2'b11) begin
      f = BASE << sel;
      m_seq.push_back(f);
      m_kind = K_HOLD;
    end else if (start_step > stop_step || inc == 0) begin
      m_seq.push_back(start_step);
      m_kind = K_HOLD;
      m_done = 1'b1;
    end else begin
      // Up leg: start, then each step clamped to stop, ending on stop.
      s = longint'(start_step);
      m_seq.push_back(start_step);
      do begin
        s = s + longint'(inc);
        if (s > longint'(stop_step)) s = longint'(stop_step);
        m_seq.push_back(32'(s));
      end while (s < longint'(stop_step));
      // Down leg for the triangle: back to start, clamped.
      if (m_tri) begin
        do begin
          s = s - longint'(inc);
          if (s < longint'(start_step)) s = longint'(start_step);
          m_seq.push_back(32'(s));
        end while (s > longint'(start_step));
      end
      m_kind = K_SWEEP;
    end
  endfunction

  function automatic void model_clock();
    m_done = 1'b0;
    if (load) begin
      model_load();
    end else if (m_kind == K_SWEEP && sample_en && !hold) begin
      if (m_cnt == m_dwell - 1) begin
        m_cnt = 0;
        // After a full triangle the walk resumes at the first up step.
        if (m_idx == m_seq.size() - 1) m_idx = 1;
        else m_idx++;
        if (m_idx == m_seq.size() - 1) begin
          m_done = 1'b1;
          if (!m_tri) m_kind = K_HOLD;
        end
      end else begin
        m_cnt++;
      end
    end
  endfunction

  function automatic logic [34:0] exp_vec();
    logic [31:0] st;
    st = (m_kind == K_IDLE) ? 32'h0 : m_seq[m_idx];
    return {st, m_valid, (m_kind == K_SWEEP), m_done};
  endfunction

  function automatic string diag();
    logic [34:0] e;
    e = exp_vec();
    return $sformatf("got step=%h valid=%b busy=%b done=%b, expected step=%h valid=%b busy=%b done=%b",
                     phase_step, step_valid, busy, sweep_done, e[34:3], e[2], e[1], e[0]);
  endfunction

  // One clock: model follows the inputs the DUT saw at the edge; returns
  // 1 time unit after the edge so outputs are settled.
  task automatic cycle();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_clock();
    #1;
  endtask

  task automatic do_load(input logic [1:0] md, input logic [SW-1:0] sl,
                         input logic [PW-1:0] st, input logic [PW-1:0] sp,
                         input logic [PW-1:0] ic, input logic [DW-1:0] dw);
    mode = md; sel = sl; start_step = st; stop_step = sp; inc = ic; dwell = dw;
    load = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    cycle();
    cycle();
    vectors++;
    if ({phase_step, step_valid, busy, sweep_done} !== 35'h0) begin
      miscompares++;
      $display("FAIL reset_held %s", diag());
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      vectors++;
      if ({phase_step, step_valid, busy, sweep_done} !== exp_vec()) begin
        miscompares++;
        $display("FAIL reset_idle cyc=%0d %s", i, diag());
      end
    end
  endtask

  task automatic test_fixed();
    logic [31:0] want;
    for (int s = 0; s < 5; s++) begin
      // Last pass uses the reserved mode, which must behave as fixed.
      do_load((s == 4) ? 2'b11 : 2'b00, SW'(s % 4), 32'h1234, 32'h10, 32'h1, 16'd1);
      sample_en = 1'b1;
      cycle();
      load = 1'b0;
      want = 32'h0080_0000 << (s % 4);
      vectors++;
      if ({phase_step, step_valid, busy, sweep_done} !== exp_vec() || phase_step !== want) begin
        miscompares++;
        $display("FAIL fixed_sel%0d const=%h %s", s % 4, want, diag());
      end
      cycle();
      vectors++;
      if ({phase_step, step_valid, busy, sweep_done} !== exp_vec()) begin
        miscompares++;
        $display("FAIL fixed_hold sel=%0d %s", s % 4, diag());
      end
    end
  endtask

  task automatic test_up_sweep();
    int pulses = 0;
    do_load(2'b01, '0, 32'd100, 32'd130, 32'd10, 16'd2);
    sample_en = 1'b1;
    hold = 1'b0;
    for (int i = 0; i < 14; i++) begin
      cycle();
      load = 1'b0;
      if (sweep_done === 1'b1) pulses++;
      vectors++;
      if ({phase_step, step_valid, busy, sweep_done} !== exp_vec()) begin
        miscompares++;
        $display("FAIL up_sweep cyc=%0d %s", i, diag());
      end
    end
    vectors++;
    if (phase_step !== 32'd130 || busy !== 1'b0 || pulses != 1) begin
      miscompares++;
      $display("FAIL up_sweep_end step=%0d busy=%b pulses=%0d, expected 130/0/1", phase_step, busy, pulses);
    end
  endtask

  task automatic test_triangle();
    logic [31:0] golden[14] = '{0, 10, 20, 25, 15, 5, 0, 10, 20, 25, 15, 5, 0, 10};
    do_load(2'b10, '0, 32'd0, 32'd25, 32'd10, 16'd1);
    sample_en = 1'b1;
    for (int i = 0; i < 14; i++) begin
      cycle();
      load = 1'b0;
      vectors++;
      if ({phase_step, step_valid, busy, sweep_done} !== exp_vec() || phase_step !== golden[i]) begin
        miscompares++;
        $display("FAIL triangle cyc=%0d golden=%0d %s", i, golden[i], diag());
      end
    end
  endtask

  task automatic test_clamp_and_invalid();
    do_load(2'b01, '0, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 16'd1);
    sample_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      load = 1'b0;
      vectors++;
      if ({phase_step, step_valid, busy, sweep_done} !== exp_vec()) begin
        miscompares++;
        $display("FAIL clamp_top cyc=%0d %s", i, diag());
      end
    end
    // start > stop, then inc = 0: both park on start with an immediate pulse.
    for (int k = 0; k < 2; k++) begin
      if (k == 0) do_load(2'b01, '0, 32'd50, 32'd40, 32'd5, 16'd1);
      else        do_load(2'b10, '0, 32'd70, 32'd90, 32'd0, 16'd1);
      cycle();
      load = 1'b0;
      vectors++;
      if ({phase_step, step_valid, busy, sweep_done} !== exp_vec()) begin
        miscompares++;
        $display("FAIL invalid_load k=%0d %s", k, diag());
      end
      cycle();
      vectors++;
      if ({phase_step, step_valid, busy, sweep_done} !== exp_vec()) begin
        miscompares++;
        $display("FAIL invalid_after k=%0d %s", k, diag());
      end
    end
  endtask

  task automatic test_hold_and_reload();
    do_load(2'b01, '0, 32'd0, 32'd1000, 32'd7, 16'd3);
    sample_en = 1'b1;
    hold = 1'b0;
    for (int i = 0; i < 30; i++) begin
      cycle();
      load = 1'b0;
      // Five held sample enables mid-sweep, then a hold coincident with a
      // reload near the end.
      hold = (i >= 7 && i < 12) || (i == 22);
      if (i == 22) do_load(2'b10, '0, 32'd500, 32'd530, 32'd9, 16'd2);
      vectors++;
      if ({phase_step, step_valid, busy, sweep_done} !== exp_vec()) begin
        miscompares++;
        $display("FAIL hold_reload cyc=%0d %s", i, diag());
      end
    end
    hold = 1'b0;
  endtask

  task automatic test_random();
    logic [PW-1:0] st, sp, ic;
    int len;
    for (int n = 0; n < 40; n++) begin
      st = 32'($urandom_range(0, 500));
      sp = st + 32'($urandom_range(0, 200));
      ic = 32'($urandom_range(0, 40));
      if ($urandom_range(0, 7) == 0) begin
        st = 32'hFFFF_FE00 + 32'($urandom_range(0, 255));
        sp = 32'hFFFF_FFFF;
        ic = 32'($urandom_range(1, 300));
      end
      if ($urandom_range(0, 9) == 0 && st > 0) sp = st - 1;
      do_load(2'($urandom), SW'($urandom), st, sp, ic, DW'($urandom_range(0, 3)));
      len = $urandom_range(10, 60);
      for (int i = 0; i < len; i++) begin
        cycle();
        load = 1'b0;
        sample_en = ($urandom_range(0, 2) != 0);
        hold = ($urandom_range(0, 7) == 0);
        vectors++;
        if ({phase_step, step_valid, busy, sweep_done} !== exp_vec()) begin
          miscompares++;
          $display("FAIL random cfg=%0d cyc=%0d %s", n, i, diag());
        end
      end
    end
    hold = 1'b0;
  endtask

  task automatic test_async_reset();
    do_load(2'b10, '0, 32'd10, 32'd200, 32'd15, 16'd1);
    sample_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycle();
      load = 1'b0;
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    vectors++;
    if ({phase_step, step_valid, busy, sweep_done} !== 35'h0) begin
      miscompares++;
      $display("FAIL async_reset_immediate %s", diag());
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      vectors++;
      if ({phase_step, step_valid, busy, sweep_done} !== exp_vec()) begin
        miscompares++;
        $display("FAIL after_reset cyc=%0d %s", i, diag());
      end
    end
    sample_en = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired before completion");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    test_reset();
    test_fixed();
    test_up_sweep();
    test_triangle();
    test_clamp_and_invalid();
    test_hold_and_reload();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/phase_step_sweep_ctrl.md
Name: phase_step_sweep_ctrl

Overview:
Parametrised successor to the fixed frequency selector for the DDS waveform generator. It registers the phase-accumulator step and supports three modes:
- fixed power-of-two frequency select;
- one-shot linear up-sweep (chirp);
- continuous triangle sweep.

All changes are timed by the sample-rate enable so the downstream phase accumulator and FIR/IIR test path see glitch-free frequency updates.

Parameters:
PHASE_W, 32, width of phase step and all step-related inputs.
SEL_W, 2, width of fixed-mode frequency select.
DWELL_W, 16, width of dwell counter (sample enables per sweep step).
BASE_STEP, 32'h0080_0000, fixed-mode step for i_sel=0.

Ports:
i_clk  input  1  system clock, all logic rising-edge.
i_rst_n  input  1  asynchronous active-low reset.
i_load  input  1  one-cycle pulse; latches all configuration inputs and (re)starts the selected mode.
i_mode  input  2  00 fixed, 01 up-sweep, 10 triangle sweep, 11 reserved (decoded as fixed).
i_sel  input  SEL_W  fixed-mode select; step = BASE_STEP << i_sel, truncated to PHASE_W.
i_start_step  input  PHASE_W  sweep start step.
i_stop_step  input  PHASE_W  sweep stop step.
i_inc  input  PHASE_W  step increment per dwell period.
i_dwell  input  DWELL_W  sample enables per sweep step; 0 is treated as 1.
i_sample_en  input  1  sample-rate strobe, one cycle wide.
i_hold  input  1  freezes the dwell counter and step while high.
o_phase_step  output  PHASE_W  registered phase step to the accumulator.
o_step_valid  output  1  high once a configuration has been loaded.
o_busy  output  1  high in SWEEP_UP or SWEEP_DOWN.
o_sweep_done  output  1  one-cycle pulse, see below.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, o_phase_step=0, o_step_valid=0, o_busy=0, o_sweep_done=0, dwell counter=0, latched config=0.
- State machine:
  - States: IDLE, FIXED, SWEEP_UP, SWEEP_DOWN, DONE.
  - i_load in any state latches mode, sel, start, stop, inc and dwell, clears the dwell counter and enters the new state on the next edge. Sweeps restart from start; a load mid-sweep aborts the current sweep without a done pulse.
- Load latency:
  - o_phase_step takes its new value exactly 1 cycle after i_load, and o_step_valid is set at the same edge.
  - Fixed modes (00, 11) go to FIXED with step = BASE_STEP << sel.
  - Modes 01/10 with a valid configuration go to SWEEP_UP with step=start.
- Invalid sweep configuration (start > stop, or inc = 0):
  - Step=start, state=DONE, o_sweep_done pulses at the same edge.
- Dwell:
  - In SWEEP states, each i_sample_en with i_hold low increments the dwell counter.
  - When the counter reaches max(i_dwell,1)-1 and i_sample_en is high, the counter clears and the step advances on that edge.
  - i_hold high ignores i_sample_en and freezes both counter and step.
- Advance in SWEEP_UP:
  - Compute next = step + inc in PHASE_W+1 bits. If next >= stop (including carry), step=stop; otherwise step=next.
  - On reaching stop in mode 01: go to DONE and pulse o_sweep_done.
  - On reaching stop in mode 10: go to SWEEP_DOWN, no pulse.
- Advance in SWEEP_DOWN:
  - If step - inc underflows or is <= start, step=start, go to SWEEP_UP and pulse o_sweep_done (one per full triangle period). Otherwise step = step - inc.
- Steady states:
  - FIXED and DONE hold the step indefinitely and ignore i_sample_en and i_hold.
  - IDLE holds 0.
- Output rules:
  - o_busy = (state==SWEEP_UP or SWEEP_DOWN), registered with the state.
  - o_sweep_done is never high for two consecutive cycles.
  - o_phase_step never exceeds stop and never goes below start during a sweep.
- Simultaneous events:
  - i_load has priority over a same-cycle advance; the advance is discarded.
  - i_hold and i_load in the same cycle: the load is taken and the hold applies from the next cycle.
- Reset asserted mid-sweep: all outputs return to their reset values immediately.

Test Plan:
1. Reset, then i_load with mode=00 and i_sel=0,1,2,3 in turn -> o_phase_step = 0x0080_0000, 0x0100_0000, 0x0200_0000, 0x0400_0000, each 1 cycle after its load; o_busy=0.
2. Mode=01, start=100, stop=130, inc=10, dwell=2, i_sample_en every cycle -> step goes 100,110,120,130, changing every 2 cycles. o_sweep_done pulses once when 130 is reached, then step holds 130 and o_busy=0.
3. Mode=10, start=0, stop=25, inc=10, dwell=1 -> step goes 0,10,20,25,15,5,0,10,... with o_sweep_done pulsing each time step returns to 0.
4. Mode=01, start=0xFFFF_FFF0, stop=0xFFFF_FFFF, inc=0x20 -> next step clamps to 0xFFFF_FFFF without wrap and done pulses. Separately, start=50, stop=40 -> step=50, done pulses at the load edge.
5. During a sweep, hold i_hold high for 5 sample enables -> step and dwell count are frozen and resume exactly where they stopped. A new i_load issued mid-sweep -> restart at the new start 1 cycle later with no done pulse.
6. Assert i_rst_n low asynchronously mid-sweep (between clock edges) -> all outputs are 0 immediately; after release, outputs stay in IDLE with step 0 until the next i_load.
